// File: rtl/config_stream_sequencer.sv
// Buffers 32-bit bitstream words and serialises each one LSB-first onto four
// 8-bit config chain lanes. After the programmed word count it issues one set pulse and then signals done.
module config_stream_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] num_words_i,
  input  logic             free_run_i,
  input  logic [31:0]      word_i,
  input  logic             word_valid_i,
  output logic             word_ready_o,
  output logic             cen,
  output logic [3:0]       shift_out,
  output logic [3:0]       set_out,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] words_left_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_SET, S_DONE} state_t;
  state_t state, state_nx;

  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      fifo_cnt, fifo_cnt_nx;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] words_left, accept_left;
  logic [2:0]       bit_idx;
  logic [31:0]      shreg;

  logic start_ok, abort_busy, push, fifo_wr, fifo_rd, fifo_bypass, load_word;

  assign busy_o       = (state != S_IDLE);
  assign fifo_empty   = (fifo_cnt == '0);
  assign word_ready_o = busy_o & ~fifo_full & (accept_left != '0);
  assign push         = word_valid_i & word_ready_o;
  assign start_ok     = (state == S_IDLE) & start_i & ~abort_i;
  assign abort_busy   = abort_i & busy_o;

  // An empty FIFO is bypassed in LOAD so a word handed over that cycle
  // starts shifting immediately, keeping the per-word cost at 9 cycles.
  assign fifo_rd     = (state == S_LOAD) & ~fifo_empty;
  assign fifo_bypass = (state == S_LOAD) & fifo_empty & push;
  assign fifo_wr     = push & ~fifo_bypass;
  assign load_word   = fifo_rd | fifo_bypass;
  assign fifo_cnt_nx = fifo_cnt + (AW+1)'(fifo_wr) - (AW+1)'(fifo_rd);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state       <= S_IDLE;
      words_left  <= '0;
      accept_left <= '0;
      bit_idx     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      fifo_full   <= 1'b0;
    end else begin
      state <= state_nx;
      if (abort_busy) begin
        words_left  <= '0;
        accept_left <= '0;
        bit_idx     <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        fifo_cnt    <= '0;
        fifo_full   <= 1'b0;
      end else begin
        if (start_ok) begin
          words_left  <= num_words_i;
          accept_left <= num_words_i;
        end else if (push && accept_left != '0) begin
          accept_left <= accept_left - CNT_W'(1);
        end
        if (load_word)
          bit_idx <= '0;
        else if (state == S_SHIFT)
          bit_idx <= bit_idx + 3'd1;
        if (state == S_SHIFT && bit_idx == 3'd7 && words_left != '0)
          words_left <= words_left - CNT_W'(1);
        if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
        if (fifo_rd) rd_ptr <= rd_ptr + AW'(1);
        fifo_cnt  <= fifo_cnt_nx;
        fifo_full <= (fifo_cnt_nx == (AW+1)'(FIFO_DEPTH));
      end
    end
  end

  // Word storage and the shift register carry data only; control gates them.
  always_ff @(posedge wb_clk_i) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= word_i;
    if (load_word) shreg <= fifo_rd ? fifo_mem[rd_ptr] : word_i;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_ok) state_nx = (num_words_i != '0) ? S_LOAD : S_DONE;
      S_LOAD:  if (load_word) state_nx = S_SHIFT;
      S_SHIFT: if (bit_idx == 3'd7)
                 state_nx = (words_left <= CNT_W'(1)) ? S_SET : S_LOAD;
      S_SET:   state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort_busy) state_nx = S_IDLE;
  end

  always_comb begin
    shift_out = '0;
    if (state == S_SHIFT)
      for (int k = 0; k < 4; k++) shift_out[k] = shreg[{k[1:0], bit_idx}];
  end

  assign cen          = free_run_i | (state == S_SHIFT) | (state == S_SET);
  assign set_out      = (state == S_SET) ? 4'b1111 : 4'b0000;
  assign done_o       = (state == S_DONE);
  assign words_left_o = words_left;

endmodule

// File: tb/tb_config_stream_sequencer.sv
// Bench for config_stream_sequencer: a vector table, directed corner cases and
// randomized loads checked against a word-timing reference model.
`timescale 1ns/1ps
module tb_config_stream_sequencer;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i, abort_i, free_run_i, word_valid_i;
  logic [CW-1:0] num_words_i;
  logic [31:0]   word_i;
  logic          word_ready_o, cen, busy_o, done_o;
  logic [3:0]    shift_out, set_out;
  logic [CW-1:0] words_left_o;

  int n_checks = 0;
  int n_fail   = 0;

  config_stream_sequencer #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start_i), .abort_i(abort_i),
    .num_words_i(num_words_i), .free_run_i(free_run_i), .word_i(word_i),
    .word_valid_i(word_valid_i), .word_ready_o(word_ready_o), .cen(cen),
    .shift_out(shift_out), .set_out(set_out), .busy_o(busy_o), .done_o(done_o),
    .words_left_o(words_left_o)
  );

  always #5 clk = ~clk;

  function automatic logic [28:0] pk(input logic rdy, input logic c, input logic [3:0] sh,
                                     input logic [3:0] st, input logic b, input logic d,
                                     input logic [CW-1:0] wl);
    return {rdy, c, sh, st, b, d, wl};
  endfunction

  function automatic logic [28:0] obs();
    return {word_ready_o, cen, shift_out, set_out, busy_o, done_o, words_left_o};
  endfunction

  // Bit b of each byte lane: lane k drives chain k.
  function automatic logic [3:0] lane_bits(input logic [31:0] w, input int b);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = w[8*k + b];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          start;
    logic          abort;
    logic          fr;
    logic [CW-1:0] nw;
    logic          valid;
    logic [31:0]   word;
    logic [28:0]   exp;
  } vec_t;

  vec_t        tbl [17];
  logic [31:0] t_word  [16];
  int          t_avail [16];

  function automatic vec_t mk(input logic st, input logic ab, input logic fr, input int nw,
                              input logic v, input logic [31:0] w, input logic [28:0] e);
    vec_t r;
    r.start = st; r.abort = ab; r.fr = fr; r.nw = CW'(nw); r.valid = v; r.word = w; r.exp = e;
    return r;
  endfunction

  // Reference model: word k starts shifting one cycle after the later of its
  // LOAD cycle and its handshake; each word then owns 8 SHIFT cycles.
  task automatic run_load(input string name, input int n, input int m, input logic fr,
                          input int abort_at, input int restart_at);
    int s [16];
    int acc, cyc, set_cyc, k_shift, done_words, popped, cload;
    logic fin, cen_e, busy_e, rdy_e, done_e;
    logic [3:0] sh_e, set_e;
    acc = 0; fin = 1'b0;
    free_run_i = fr; abort_i = 1'b0;
    start_i = 1'b1; num_words_i = CW'(n);
    word_valid_i = (m > 0 && t_avail[0] == 0); word_i = t_word[0];
    @(posedge clk); #2;
    start_i = 1'b0;
    cyc = 1;
    while (!fin) begin
      set_cyc = (acc >= n) ? s[n-1] + 8 : -1;
      busy_e  = (set_cyc < 0) || (cyc <= set_cyc + 1);
      sh_e = 4'h0; k_shift = -1; done_words = 0; popped = 0;
      for (int k = 0; k < acc; k++) begin
        if (cyc >= s[k] && cyc <= s[k] + 7) begin
          k_shift = k;
          sh_e = lane_bits(t_word[k], cyc - s[k]);
        end
        if (s[k] + 8 <= cyc) done_words++;
        if (s[k] - 1 <= cyc - 1) popped++;
      end
      set_e  = (set_cyc >= 0 && cyc == set_cyc) ? 4'hF : 4'h0;
      done_e = (set_cyc >= 0 && cyc == set_cyc + 1);
      cen_e  = fr | (k_shift >= 0) | (set_e != 4'h0);
      rdy_e  = busy_e && (acc - popped) < DEPTH && acc < n;
      check($sformatf("%s cyc=%0d", name, cyc), 32'(obs()),
            32'(pk(rdy_e, cen_e, sh_e, set_e, busy_e, done_e, CW'(n - done_words))));
      if (abort_at != 0 && cyc == abort_at) begin
        word_valid_i = 1'b0;
        abort_i = 1'b1;
        @(posedge clk); #2;
        abort_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
          check($sformatf("%s post-abort %0d", name, i), 32'(obs()), 32'(pk(0, fr, 0, 0, 0, 0, 0)));
          @(posedge clk); #2;
        end
        fin = 1'b1;
      end else begin
        start_i = (cyc == restart_at);
        num_words_i = (cyc == restart_at) ? CW'(n + 3) : CW'(n);
        if (acc < m && cyc >= t_avail[acc]) begin
          word_valid_i = 1'b1;
          word_i = t_word[acc];
        end else begin
          word_valid_i = 1'b0;
        end
        if (word_valid_i && word_ready_o && acc < 16) begin
          cload = (acc == 0) ? 1 : s[acc-1] + 8;
          s[acc] = ((cload > cyc) ? cload : cyc) + 1;
          acc++;
        end
        if ((set_cyc >= 0 && cyc >= set_cyc + 2) || cyc > 800) begin
          if (cyc > 800) check($sformatf("%s timeout", name), 32'(cyc), 32'(0));
          fin = 1'b1;
        end else begin
          @(posedge clk); #2;
          cyc++;
        end
      end
    end
    word_valid_i = 1'b0; start_i = 1'b0;
    if (abort_at == 0) check($sformatf("%s handshakes", name), 32'(acc), 32'(n));
  endtask

  initial begin
    logic [31:0] w0;
    int n, m;
    w0 = 32'hA5C3_0F81;
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; free_run_i = 1'b0;
    word_valid_i = 1'b0; word_i = '0; num_words_i = '0;

    tbl[0]  = mk(1, 0, 0, 1, 1, w0, pk(1, 0, 4'h0, 4'h0, 1, 0, 1));
    tbl[1]  = mk(0, 0, 0, 1, 1, w0, pk(0, 1, 4'hF, 4'h0, 1, 0, 1));
    tbl[2]  = mk(0, 0, 0, 1, 0, w0, pk(0, 1, 4'h6, 4'h0, 1, 0, 1));
    tbl[3]  = mk(0, 0, 0, 1, 0, w0, pk(0, 1, 4'hA, 4'h0, 1, 0, 1));
    tbl[4]  = mk(0, 0, 0, 1, 0, w0, pk(0, 1, 4'h2, 4'h0, 1, 0, 1));
    tbl[5]  = mk(0, 0, 0, 1, 0, w0, pk(0, 1, 4'h0, 4'h0, 1, 0, 1));
    tbl[6]  = mk(0, 0, 0, 1, 0, w0, pk(0, 1, 4'h8, 4'h0, 1, 0, 1));
    tbl[7]  = mk(0, 0, 0, 1, 0, w0, pk(0, 1, 4'h4, 4'h0, 1, 0, 1));
    tbl[8]  = mk(0, 0, 0, 1, 0, w0, pk(0, 1, 4'hD, 4'h0, 1, 0, 1));
    tbl[9]  = mk(0, 0, 0, 1, 0, w0, pk(0, 1, 4'h0, 4'hF, 1, 0, 0));
    tbl[10] = mk(0, 0, 0, 1, 0, w0, pk(0, 0, 4'h0, 4'h0, 1, 1, 0));
    tbl[11] = mk(0, 0, 0, 1, 0, w0, pk(0, 0, 4'h0, 4'h0, 0, 0, 0));
    tbl[12] = mk(1, 1, 0, 1, 0, w0, pk(0, 0, 4'h0, 4'h0, 0, 0, 0));
    tbl[13] = mk(1, 0, 0, 0, 0, w0, pk(0, 0, 4'h0, 4'h0, 1, 1, 0));
    tbl[14] = mk(0, 0, 0, 0, 0, w0, pk(0, 0, 4'h0, 4'h0, 0, 0, 0));
    tbl[15] = mk(0, 0, 1, 0, 0, w0, pk(0, 1, 4'h0, 4'h0, 0, 0, 0));
    tbl[16] = mk(0, 0, 0, 0, 0, w0, pk(0, 0, 4'h0, 4'h0, 0, 0, 0));

    repeat (2) @(posedge clk);
    #2;
    check("reset state", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 0, 0)));
    rst_n = 1'b1;
    @(posedge clk); #2;
    check("idle after reset", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 0, 0)));

    for (int i = 0; i < 17; i++) begin
      start_i = tbl[i].start; abort_i = tbl[i].abort; free_run_i = tbl[i].fr;
      num_words_i = tbl[i].nw; word_valid_i = tbl[i].valid; word_i = tbl[i].word;
      @(posedge clk); #2;
      check($sformatf("vec %0d", i), 32'(obs()), 32'(tbl[i].exp));
    end
    start_i = 1'b0; abort_i = 1'b0; word_valid_i = 1'b0;

    for (int k = 0; k < 16; k++) begin t_word[k] = $urandom; t_avail[k] = 0; end
    t_avail[1] = 15;
    run_load("stall", 2, 2, 1'b0, 0, 0);
    t_avail[1] = 0;
    run_load("backpressure", 3, 6, 1'b0, 0, 0);
    run_load("fifo full", 8, 8, 1'b0, 0, 0);
    run_load("start busy", 3, 3, 1'b0, 0, 5);
    run_load("abort", 4, 4, 1'b0, 14, 0);
    t_avail[0] = 4;
    run_load("after abort", 1, 1, 1'b0, 0, 0);

    // Asynchronous reset in the middle of a word.
    t_avail[0] = 0;
    start_i = 1'b1; num_words_i = CW'(4); word_valid_i = 1'b1; word_i = t_word[0];
    @(posedge clk); #2;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset outputs", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 0, 0)));
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check($sformatf("post-reset idle %0d", i), 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 0, 0)));
    end
    word_valid_i = 1'b0;
    t_avail[0] = 4;
    run_load("after reset", 1, 1, 1'b0, 0, 0);

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 7);
      m = n + $urandom_range(0, 2);
      t_avail[0] = $urandom_range(0, 3);
      t_word[0] = $urandom;
      for (int k = 1; k < 16; k++) begin
        t_avail[k] = t_avail[k-1] + $urandom_range(0, 14);
        t_word[k] = $urandom;
      end
      run_load($sformatf("random %0d", r), n, m, 1'($urandom_range(0, 1)), 0, 0);
    end

    free_run_i = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
